// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and sizing for the SRAM controller
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;
  // Wide enough to hold STROBE_CYC-1 for every legal STROBE_CYC (1..15)
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port asynchronous SRAM controller with setup/strobe/hold timing
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_re,
  output logic              sram_we,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              busy
);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we, r_req_ready, r_busy, r_sram_re, r_sram_we, r_drive, r_rsp_valid;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [DATA_W-1:0]   r_wdata, r_rsp_rdata;
  logic                w_accept, w_last;
  logic                w_we_nxt, w_ready_nxt, w_busy_nxt, w_re_nxt, w_wen_nxt;
  logic                w_drive_nxt, w_rsp_nxt;

  assign w_accept = (r_state == ST_IDLE) && req_valid && r_req_ready;
  assign w_last   = (r_cnt == CNT_W'(STROBE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: if (w_last) w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it
  always_comb begin
    w_we_nxt    = w_accept ? req_we : r_we;
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_re_nxt    = (w_state_nxt == ST_STROBE) && !w_we_nxt;
    w_wen_nxt   = (w_state_nxt == ST_STROBE) && w_we_nxt;
    w_drive_nxt = w_busy_nxt && w_we_nxt;
    w_rsp_nxt   = (w_state_nxt == ST_HOLD) && !w_we_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_sram_re   <= 1'b0;
      r_sram_we   <= 1'b0;
      r_drive     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_sram_addr <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_cnt       <= (r_state == ST_STROBE) ? r_cnt + CNT_W'(1) : '0;
      r_we        <= w_we_nxt;
      r_req_ready <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_sram_re   <= w_re_nxt;
      r_sram_we   <= w_wen_nxt;
      r_drive     <= w_drive_nxt;
      r_rsp_valid <= w_rsp_nxt;
      if (w_accept) begin
        r_sram_addr <= req_addr;
        r_wdata     <= req_wdata;
      end
      if ((r_state == ST_STROBE) && w_last && !r_we) r_rsp_rdata <= sram_data;
    end
  end

  assign sram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign sram_re   = r_sram_re;
  assign sram_we   = r_sram_we;
  assign sram_addr = r_sram_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed bench for sram_ctrl with behavioural SRAMs (STROBE_CYC 2 and 1)
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        valid0 = 0, ready0, we0 = 0, rsp_v0, sre0, swe0, busy0;
  logic [12:0] addr0 = 0, saddr0;
  logic [7:0]  wdata0 = 0, rdata0;
  wire  [7:0]  sdata0;
  logic        valid1 = 0, ready1, we1 = 0, rsp_v1, sre1, swe1, busy1;
  logic [12:0] addr1 = 0, saddr1;
  logic [7:0]  wdata1 = 0, rdata1;
  wire  [7:0]  sdata1;

  sram_ctrl #(.ADDR_W(13), .DATA_W(8), .STROBE_CYC(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0), .req_we(we0),
    .req_addr(addr0), .req_wdata(wdata0), .rsp_valid(rsp_v0), .rsp_rdata(rdata0),
    .sram_addr(saddr0), .sram_re(sre0), .sram_we(swe0), .sram_data(sdata0), .busy(busy0));

  sram_ctrl #(.ADDR_W(13), .DATA_W(8), .STROBE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1), .req_we(we1),
    .req_addr(addr1), .req_wdata(wdata1), .rsp_valid(rsp_v1), .rsp_rdata(rdata1),
    .sram_addr(saddr1), .sram_re(sre1), .sram_we(swe1), .sram_data(sdata1), .busy(busy1));

  // Behavioural SRAMs; the pull-ups make an undriven bus read back as 8'hFF
  logic [7:0] mem0 [0:8191];
  logic [7:0] mem1 [0:8191];
  pullup (sdata0);
  pullup (sdata1);
  assign sdata0 = (sre0 && !swe0) ? mem0[saddr0] : 8'hzz;
  assign sdata1 = (sre1 && !swe1) ? mem1[saddr1] : 8'hzz;
  always @(posedge clk) if (swe0) mem0[saddr0] <= sdata0;
  always @(posedge clk) if (swe1) mem1[saddr1] <= sdata1;

  int tests = 0, fails = 0;
  int cyc = 0;
  int acc_cnt0 = 0, acc_edge0 = 0, acc_cnt1 = 0, acc_edge1 = 0;
  int rsp_edge0 = 0, rsp_edge1 = 0, wide0 = 0, both0 = 0;
  logic prev0 = 0;
  logic [7:0] rsp_q0 [$];
  logic [7:0] rsp_q1 [$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (valid0 && ready0) begin acc_cnt0++; acc_edge0 = cyc; end
    if (valid1 && ready1) begin acc_cnt1++; acc_edge1 = cyc; end
  end

  always @(negedge clk) begin
    if (rsp_v0) begin rsp_q0.push_back(rdata0); rsp_edge0 = cyc; end
    if (rsp_v1) begin rsp_q1.push_back(rdata1); rsp_edge1 = cyc; end
    if (rsp_v0 && prev0) wide0++;
    if (sre0 && swe0) both0++;
    prev0 = rsp_v0;
  end

  task automatic do_req0(input logic we, input logic [12:0] a, input logic [7:0] d, output int zbad);
    int a0;
    bit done;
    a0 = acc_cnt0; zbad = 0; done = 0;
    valid0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = (acc_cnt0 != a0);
    end
    valid0 = 1'b0;
    tests++;
    if (!done) begin fails++; $display("FAIL req_accept: no acceptance, required within 20 cycles"); end
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (!we && !sre0 && sdata0 !== 8'hFF) zbad++;
      if (ready0) done = 1; else @(negedge clk);
    end
    tests++;
    if (!done) begin fails++; $display("FAIL req_done: ready stayed low, required high within 20 cycles"); end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b required 0", ready0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy0); end
    tests++; if ({sre0, swe0, rsp_v0} !== 3'b000) begin fails++; $display("FAIL rst_strobes: got %b required 000", {sre0, swe0, rsp_v0}); end
    tests++; if (saddr0 !== 13'd0 || rdata0 !== 8'd0) begin fails++; $display("FAIL rst_addr_rdata: got %h/%h required 0/0", saddr0, rdata0); end
    tests++; if (sdata0 !== 8'hFF) begin fails++; $display("FAIL rst_bus_z: got %h required FF (undriven)", sdata0); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin fails++; $display("FAIL rst_release: ready/busy %b%b required 10", ready0, busy0); end
  endtask

  task automatic test_basic();
    int zb;
    rsp_q0.delete(); wide0 = 0;
    do_req0(1'b1, 13'd0, 8'h05, zb);
    do_req0(1'b1, 13'd1, 8'h08, zb);
    tests++; if (rsp_q0.size() != 0) begin fails++; $display("FAIL write_no_rsp: got %0d pulses required 0", rsp_q0.size()); end
    do_req0(1'b0, 13'd0, 8'h00, zb);
    tests++; if (rsp_edge0 - acc_edge0 != 3) begin fails++; $display("FAIL read0_latency: got %0d edges required 3", rsp_edge0 - acc_edge0); end
    do_req0(1'b0, 13'd1, 8'h00, zb);
    tests++; if (rsp_edge0 - acc_edge0 != 3) begin fails++; $display("FAIL read1_latency: got %0d edges required 3", rsp_edge0 - acc_edge0); end
    tests++; if (rsp_q0.size() != 2) begin fails++; $display("FAIL basic_rsp_count: got %0d required 2", rsp_q0.size()); end
    tests++; if (rsp_q0[0] !== 8'h05) begin fails++; $display("FAIL basic_read0: got %h required 05", rsp_q0[0]); end
    tests++; if (rsp_q0[1] !== 8'h08) begin fails++; $display("FAIL basic_read1: got %h required 08", rsp_q0[1]); end
    tests++; if (wide0 != 0) begin fails++; $display("FAIL rsp_width: got %0d wide pulses required 0", wide0); end
  endtask

  task automatic test_overwrite();
    int zb;
    rsp_q0.delete(); both0 = 0;
    do_req0(1'b1, 13'd1, 8'h08, zb);
    do_req0(1'b1, 13'd1, 8'h06, zb);
    do_req0(1'b0, 13'd1, 8'h00, zb);
    tests++; if (rsp_q0.size() != 1 || rsp_q0[0] !== 8'h06) begin fails++; $display("FAIL overwrite_read: got %h (n=%0d) required 06", rsp_q0[0], rsp_q0.size()); end
    tests++; if (zb != 0) begin fails++; $display("FAIL read_bus_z: got %0d driven cycles required 0", zb); end
    tests++; if (both0 != 0) begin fails++; $display("FAIL re_we_both: got %0d cycles required 0", both0); end
    do_req0(1'b1, 13'd2, 8'h99, zb);
    tests++; if (rdata0 !== 8'h06) begin fails++; $display("FAIL rdata_hold: got %h required 06", rdata0); end
  endtask

  task automatic test_back_to_back();
    logic        wv [4];
    logic [12:0] av [4];
    logic [7:0]  dv [4];
    int edges [4];
    int n, idle, a0;
    wv[0] = 1'b1; av[0] = 13'd2; dv[0] = 8'h11;
    wv[1] = 1'b0; av[1] = 13'd2; dv[1] = 8'h00;
    wv[2] = 1'b1; av[2] = 13'd4; dv[2] = 8'h22;
    wv[3] = 1'b0; av[3] = 13'd4; dv[3] = 8'h00;
    rsp_q0.delete(); n = 0; idle = 0; a0 = acc_cnt0;
    valid0 = 1'b1; we0 = wv[0]; addr0 = av[0]; wdata0 = dv[0];
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (acc_cnt0 != a0) begin
        a0 = acc_cnt0; edges[n] = acc_edge0; n++;
        if (n < 4) begin we0 = wv[n]; addr0 = av[n]; wdata0 = dv[n]; end
        else valid0 = 1'b0;
      end else if (n > 0 && !busy0) idle++;
    end
    valid0 = 1'b0;
    tests++; if (n != 4) begin fails++; $display("FAIL b2b_accepts: got %0d required 4", n); end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (edges[i] - edges[i-1] != 5) begin fails++; $display("FAIL b2b_spacing%0d: got %0d required 5", i, edges[i] - edges[i-1]); end
    end
    tests++; if (idle != 3) begin fails++; $display("FAIL b2b_idle_gaps: got %0d idle cycles required 3", idle); end
    for (int c = 0; c < 20 && !ready0; c++) @(negedge clk);
    tests++; if (rsp_q0.size() != 2 || rsp_q0[0] !== 8'h11 || rsp_q0[1] !== 8'h22) begin
      fails++; $display("FAIL b2b_data: got n=%0d %h %h required 11 22", rsp_q0.size(), rsp_q0[0], rsp_q0[1]);
    end
  endtask

  task automatic test_reset_abort();
    int a0, n_rsp, zb;
    bit done;
    a0 = acc_cnt0; done = 0;
    valid0 = 1'b1; we0 = 1'b1; addr0 = 13'd3; wdata0 = 8'h77;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = (acc_cnt0 != a0);
    end
    valid0 = 1'b0;
    tests++; if (!done) begin fails++; $display("FAIL abort_accept: no acceptance, required within 20 cycles"); end
    @(negedge clk);
    @(negedge clk);
    tests++; if (swe0 !== 1'b1) begin fails++; $display("FAIL abort_strobe2: sram_we %b required 1", swe0); end
    n_rsp = rsp_q0.size();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (swe0 !== 1'b0) begin fails++; $display("FAIL abort_we_drop: got %b required 0", swe0); end
    tests++; if (sdata0 !== 8'hFF) begin fails++; $display("FAIL abort_bus_z: got %h required FF (undriven)", sdata0); end
    tests++; if (busy0 !== 1'b0 || rdata0 !== 8'h00) begin fails++; $display("FAIL abort_outputs: busy/rdata %b/%h required 0/00", busy0, rdata0); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (rsp_q0.size() != n_rsp) begin fails++; $display("FAIL abort_no_rsp: got %0d pulses required 0", rsp_q0.size() - n_rsp); end
    // The model latched 8'h77 on the edge ending the first strobe cycle
    do_req0(1'b0, 13'd3, 8'h00, zb);
    tests++; if (rsp_q0.size() != n_rsp + 1 || rdata0 !== 8'h77) begin fails++; $display("FAIL abort_reread: got %h required 77", rdata0); end
    tests++; if (rsp_edge0 - acc_edge0 != 3) begin fails++; $display("FAIL abort_reread_latency: got %0d required 3", rsp_edge0 - acc_edge0); end
  endtask

  task automatic test_strobe1();
    int edges [2];
    int n, a0;
    rsp_q1.delete(); n = 0; a0 = acc_cnt1;
    valid1 = 1'b1; we1 = 1'b1; addr1 = 13'd8191; wdata1 = 8'hA5;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (acc_cnt1 != a0) begin
        a0 = acc_cnt1; edges[n] = acc_edge1; n++;
        if (n == 1) begin we1 = 1'b0; wdata1 = 8'h00; end
        else valid1 = 1'b0;
      end
    end
    valid1 = 1'b0;
    for (int c = 0; c < 20 && !ready1; c++) @(negedge clk);
    tests++; if (n != 2) begin fails++; $display("FAIL s1_accepts: got %0d required 2", n); end
    tests++; if (edges[1] - edges[0] != 4) begin fails++; $display("FAIL s1_spacing: got %0d required 4", edges[1] - edges[0]); end
    tests++; if (rsp_q1.size() != 1 || rsp_q1[0] !== 8'hA5) begin fails++; $display("FAIL s1_read: got %h (n=%0d) required A5", rsp_q1[0], rsp_q1.size()); end
    tests++; if (rsp_edge1 - acc_edge1 != 2) begin fails++; $display("FAIL s1_latency: got %0d required 2", rsp_edge1 - acc_edge1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_back_to_back();
    test_reset_abort();
    test_strobe1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13, sets the SRAM address width.
REQ-002 Parameter DATA_W, default 8, sets the SRAM data width.
REQ-003 Parameter STROBE_CYC, default 2, sets the number of cycles RE/WE is asserted; legal range is 1..15.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-006 Port req_valid, input, 1 bit: a request is present.
REQ-007 Port req_ready, output, 1 bit: the controller can accept a request.
REQ-008 Port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port req_addr, input, ADDR_W bits: request address.
REQ-010 Port req_wdata, input, DATA_W bits: write data.
REQ-011 Port rsp_valid, output, 1 bit: one-cycle pulse when read data is available.
REQ-012 Port rsp_rdata, output, DATA_W bits: read data captured from the SRAM.
REQ-013 Port sram_addr, output, ADDR_W bits: SRAM address.
REQ-014 Port sram_re, output, 1 bit: SRAM read enable, active-high.
REQ-015 Port sram_we, output, 1 bit: SRAM write enable, active-high.
REQ-016 Port sram_data, inout, DATA_W bits: bidirectional SRAM data bus.
REQ-017 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, STROBE and HOLD.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-020 On acceptance, req_we, req_addr and req_wdata SHALL be registered and the FSM SHALL go to SETUP.
REQ-021 SETUP SHALL last one cycle: sram_addr driven, both strobes low, and write data driven for writes only.
REQ-022 STROBE SHALL last exactly STROBE_CYC cycles, counted by an internal counter, with sram_we=1 for writes or sram_re=1 for reads.
REQ-023 HOLD SHALL last one cycle: strobes low, with address and write data still held; the FSM then returns to IDLE.
REQ-024 sram_re and sram_we SHALL never be 1 in the same cycle.
REQ-025 sram_data SHALL be driven only during SETUP, STROBE and HOLD of a write, and SHALL be high-impedance at all other times.
REQ-026 For reads, rsp_rdata SHALL capture sram_data on the edge that ends the last STROBE cycle.
REQ-027 For reads, rsp_valid SHALL be high for exactly one cycle (HOLD), rising STROBE_CYC+1 edges after the acceptance edge.
REQ-028 Writes SHALL produce no rsp_valid pulse.
REQ-029 rsp_rdata SHALL keep its value until the next read completes.
REQ-030 Request throughput SHALL be one per STROBE_CYC+3 cycles; req_valid held high gives back-to-back transactions with one IDLE cycle between them.
REQ-031 Inputs SHALL be ignored outside IDLE.
REQ-032 Addresses 0 and 2^ADDR_W-1 SHALL need no special handling; there is no wrap-around.
REQ-033 All outputs except sram_data SHALL be registered.

Reset
REQ-034 While rst_n=0, outputs SHALL be forced asynchronously to: FSM IDLE, req_ready=0, busy=0, sram_re=0, sram_we=0, sram_addr=0, rsp_valid=0, rsp_rdata=0, sram_data high-impedance.
REQ-035 Reset asserted mid-transaction SHALL abort it: no rsp_valid pulse, and the strobe drops within the same cycle.
REQ-036 req_ready SHALL rise on the first rising edge after rst_n deasserts.

Structure
REQ-037 Package sram_ctrl_pkg SHALL hold the state enumeration, the default ADDR_W/DATA_W, and the STROBE_CYC counter width.
REQ-038 sram_ctrl SHALL be a single module, with the tri-state driver and the strobe counter inline; no sub-module is required.
REQ-039 The bench SHALL connect sram_ctrl to the existing behavioural SRAM model (13-bit address, RE, WE, 8-bit inout data).

Verification
REQ-040 Write 5 to address 0, write 8 to address 1, read 0, read 1 -> rsp_rdata is 5 then 8, and each rsp_valid is 1 cycle wide, 3 edges after acceptance.
REQ-041 Write 8 then 6 to address 1, then read 1 -> 6; sram_data is Z throughout the read, and sram_re and sram_we are never both high.
REQ-042 req_valid held high for 4 mixed requests -> acceptances spaced exactly 5 cycles apart (STROBE_CYC=2) and busy low for 1 cycle between them.
REQ-043 rst_n dropped in the 2nd STROBE cycle of a write to address 3 -> sram_we=0 immediately, sram_data Z, no rsp_valid; after reset, a read of address 3 completes normally.
REQ-044 STROBE_CYC=1 build: write/read 0xA5 at address 8191 -> read returns 0xA5, rsp_valid rises 2 edges after acceptance, throughput is 4 cycles.
